funct_generator_mult_arb: RTL and testbench
===========================================

Name: funct_generator_mult_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined signed multiplier between N_REQ requesters (function generator channels).
- Each requester presents an operand pair with a valid/ready handshake. Results leave on one tagged valid/ready port that feeds the output FIFO.
- Owns the multiply pipeline and its stall control, and preserves result order.

Parameters:
- DATA_WIDTH, 32, signed operand width; product width is 2*DATA_WIDTH.
- N_REQ, 4, number of requesters, 2..8.
- ID_WIDTH, $clog2(N_REQ), width of the requester tag.
- MULT_LAT, 2, multiply pipeline depth in stages, 1..4.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid_i  input  N_REQ  per-requester operand valid.
- req_a_i  input  N_REQ*DATA_WIDTH  flattened signed operand A; requester k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- req_b_i  input  N_REQ*DATA_WIDTH  flattened signed operand B, same packing as req_a_i.
- req_ready_o  output  N_REQ  one-hot grant; the operands of requester k are accepted when req_valid_i[k] & req_ready_o[k].
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  downstream can accept (FIFO not full).
- res_id_o  output  ID_WIDTH  index of the requester that owns the result.
- res_data_o  output  2*DATA_WIDTH  signed product.
- busy_o  output  1  at least one pipeline stage holds a valid entry.

Behaviour:
- Reset: synchronous, active-high, takes effect on the clk edge where rst=1.
  - Clears every stage valid bit and sets the round-robin pointer to 0.
  - Forces res_valid_o=0, res_id_o=0, res_data_o=0, busy_o=0, req_ready_o=0.
  - Operations in flight are discarded with no result emitted.
  - req_ready_o stays 0 during the cycle rst is high.
- Pipeline: stages S1..S_MULT_LAT, each holding {valid, id, product}.
  - S_MULT_LAT drives res_valid_o, res_id_o and res_data_o directly from registers.
  - S_MULT_LAT advances when !valid or res_ready_i.
  - Stage k advances when stage k+1 advances or stage k+1 is empty.
  - A stage that does not advance holds its contents.
- Accept condition: can_accept = S1 advances, or S1 is empty.
- Grant (combinational):
  - If can_accept=0, req_ready_o=0.
  - Otherwise grant the first requester with req_valid_i set, searching from the pointer upward with wrap-around at N_REQ-1 to 0.
  - At most one bit of req_ready_o is set.
  - req_ready_o depends on req_valid_i in the same cycle; a grant is never given to an idle requester.
- Pointer update: on an accepted transfer from requester g, pointer becomes (g+1) mod N_REQ. With no transfer the pointer holds.
- Arithmetic:
  - Signed DATA_WIDTH x DATA_WIDTH product into 2*DATA_WIDTH bits; no truncation or saturation.
  - The product is computed in S1. S2..S_MULT_LAT are pure delay stages, and retiming by synthesis is permitted.
- Latency: an operand pair accepted at edge t appears on res_* after edge t+MULT_LAT-1, i.e. it is valid during cycle t+MULT_LAT, when there is no backpressure.
- Throughput: one operation per cycle sustained while res_ready_i=1.
- Ordering: results emerge in acceptance order.
- Backpressure: while res_valid_o=1 and res_ready_i=0, res_* stay stable.
  - Bubbles are squeezed out.
  - req_ready_o drops only once every stage is full.
- Simultaneous accept and emit in the same cycle is legal when the pipeline is full and res_ready_i=1.
- busy_o is the OR of all stage valid bits, registered as part of the same state.

Optional Feature:
- Macro: FUNCT_GEN_ARB_FIXPRIO_EN.
- Defined:
  - Requester 0 is strict highest priority: granted whenever req_valid_i[0]=1 and can_accept=1.
  - Requesters 1..N_REQ-1 are arbitrated round-robin among themselves, with the pointer ranging over 1..N_REQ-1 and reset to 1.
- Undefined: pure round-robin over all N_REQ requesters as described in Behaviour.

Test Plan:
- Reset mid-operation: fill the pipeline, assert rst for one cycle -> next cycle res_valid_o=0, busy_o=0; no stale result ever appears.
- Single requester, N_REQ=4, MULT_LAT=2: req 2 presents a=-7, b=300000 at edge t -> res_valid_o=1, res_id_o=2, res_data_o=-2100000 in cycle t+2; busy_o=0 afterwards.
- All four requesters valid continuously, res_ready_i=1 -> grants in order 0,1,2,3,0,...; one result per cycle; res_id_o sequence matches the grant order.
- Extremes, DATA_WIDTH=32: a=b=-2147483648 -> res_data_o=0x4000000000000000; a=2147483647, b=-2147483648 -> res_data_o=-0x3FFFFFFF80000000.
- Backpressure: with res_ready_i=0 for 5 cycles under continuous requests -> exactly MULT_LAT acceptances, then req_ready_o=0; res_* stable. On release, no loss or duplication and order is preserved.
- With FUNCT_GEN_ARB_FIXPRIO_EN: req0 and req1..3 all valid -> req0 granted every cycle while valid. When req0 deasserts, grants run 1,2,3,1 round-robin.

Source files
------------

// File: rtl/funct_generator_mult_arb.sv
// funct_generator_mult_arb
// Round-robin arbiter that shares one pipelined signed multiplier between
// N_REQ function-generator channels. The first stage computes the product and
// the remaining stages are pure delay. Results leave through a single tagged
// valid/ready port in the order the operands were accepted.
//
// Optional feature, macro FUNCT_GEN_ARB_FIXPRIO_EN:
//   defined   -> requester 0 has strict priority; requesters 1..N_REQ-1 share
//                a round-robin pointer that ranges over 1..N_REQ-1 (reset 1)
//   undefined -> plain round-robin over all requesters (pointer reset 0)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req_valid_i  per-requester operand valid
//   req_a_i      flattened signed operand A, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_b_i      flattened signed operand B, same packing
//   req_ready_o  one-hot grant, operands taken when valid & ready
//   res_valid_o  result valid (registered)
//   res_ready_i  downstream can accept
//   res_id_o     requester index owning the result
//   res_data_o   signed 2*DATA_WIDTH product
//   busy_o       at least one pipeline stage holds a valid entry

module funct_generator_mult_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = $clog2(N_REQ),
    parameter int MULT_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [ID_WIDTH-1:0]         res_id_o,
    output logic [2*DATA_WIDTH-1:0]     res_data_o,
    output logic                        busy_o
);

`ifdef FUNCT_GEN_ARB_FIXPRIO_EN
    localparam logic [ID_WIDTH-1:0] PTR_RESET = ID_WIDTH'(1);
`else
    localparam logic [ID_WIDTH-1:0] PTR_RESET = '0;
`endif

    logic [MULT_LAT-1:0]           r_valid;
    logic [ID_WIDTH-1:0]           r_id   [MULT_LAT];
    logic [2*DATA_WIDTH-1:0]       r_prod [MULT_LAT];
    logic [ID_WIDTH-1:0]           r_ptr;
    logic                          r_busy;

    logic [MULT_LAT-1:0]           w_adv;
    logic [MULT_LAT-1:0]           w_validNext;
    logic                          w_canAccept;
    logic [N_REQ-1:0]              w_grant;
    logic [ID_WIDTH-1:0]           w_grantId;
    logic                          w_accept;
    logic [ID_WIDTH-1:0]           w_ptrNext;
    logic signed [DATA_WIDTH-1:0]  w_a;
    logic signed [DATA_WIDTH-1:0]  w_b;
    logic signed [2*DATA_WIDTH-1:0] w_prod;

    // Advance chain from the output stage backwards: a stage may move on when
    // the stage after it moves on or is empty, which squeezes out bubbles.
    always_comb begin : advanceChain
        logic chain;
        chain = !r_valid[MULT_LAT-1] || res_ready_i;
        w_adv = '0;
        w_adv[MULT_LAT-1] = chain;
        for (int k = MULT_LAT-2; k >= 0; k--) begin
            chain    = chain || !r_valid[k+1];
            w_adv[k] = chain;
        end
        w_canAccept = w_adv[0] || !r_valid[0];
    end

    // Grant search starting at the pointer with wrap-around; only valid
    // requesters are ever granted and nothing is granted during reset.
    always_comb begin : grantSearch
        logic                found;
        logic [ID_WIDTH-1:0] cand;
        w_grant   = '0;
        w_grantId = '0;
        found     = 1'b0;
        cand      = '0;
        if (w_canAccept && !rst) begin
`ifdef FUNCT_GEN_ARB_FIXPRIO_EN
            if (req_valid_i[0]) begin
                w_grant[0] = 1'b1;
                found      = 1'b1;
            end
            for (int i = 0; i < N_REQ-1; i++) begin
                cand = ID_WIDTH'(1 + ((int'(r_ptr) - 1 + i) % (N_REQ - 1)));
                if (!found && req_valid_i[cand]) begin
                    w_grant[cand] = 1'b1;
                    w_grantId     = cand;
                    found         = 1'b1;
                end
            end
`else
            for (int i = 0; i < N_REQ; i++) begin
                cand = ID_WIDTH'((int'(r_ptr) + i) % N_REQ);
                if (!found && req_valid_i[cand]) begin
                    w_grant[cand] = 1'b1;
                    w_grantId     = cand;
                    found         = 1'b1;
                end
            end
`endif
        end
    end

    // Pointer moves just past the granted requester; a requester-0 grant in
    // fixed-priority mode leaves the round-robin pointer untouched.
    always_comb begin : pointerNext
        w_accept  = |w_grant;
        w_ptrNext = r_ptr;
`ifdef FUNCT_GEN_ARB_FIXPRIO_EN
        if (w_accept && (w_grantId != '0))
            w_ptrNext = (w_grantId == ID_WIDTH'(N_REQ-1)) ? ID_WIDTH'(1) : w_grantId + ID_WIDTH'(1);
`else
        if (w_accept)
            w_ptrNext = (w_grantId == ID_WIDTH'(N_REQ-1)) ? '0 : w_grantId + ID_WIDTH'(1);
`endif
    end

    assign w_a    = req_a_i[w_grantId*DATA_WIDTH +: DATA_WIDTH];
    assign w_b    = req_b_i[w_grantId*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod = (2*DATA_WIDTH)'(w_a) * (2*DATA_WIDTH)'(w_b);

    // Stage k reloads whenever the stage before it advances; S1 reloads
    // whenever it is free, taking a bubble if nothing was granted.
    always_comb begin : validNext
        w_validNext = r_valid;
        if (w_canAccept)
            w_validNext[0] = w_accept;
        for (int k = 1; k < MULT_LAT; k++) begin
            if (w_adv[k-1])
                w_validNext[k] = r_valid[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= PTR_RESET;
            for (int k = 0; k < MULT_LAT; k++) begin
                r_id[k]   <= '0;
                r_prod[k] <= '0;
            end
        end else begin
            r_valid <= w_validNext;
            r_busy  <= |w_validNext;
            if (w_accept)
                r_ptr <= w_ptrNext;
            if (w_canAccept) begin
                r_id[0]   <= w_grantId;
                r_prod[0] <= w_accept ? w_prod : '0;
            end
            for (int k = 1; k < MULT_LAT; k++) begin
                if (w_adv[k-1]) begin
                    r_id[k]   <= r_id[k-1];
                    r_prod[k] <= r_prod[k-1];
                end
            end
        end
    end

    assign req_ready_o = w_grant;
    assign res_valid_o = r_valid[MULT_LAT-1];
    assign res_id_o    = r_id[MULT_LAT-1];
    assign res_data_o  = r_prod[MULT_LAT-1];
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_funct_generator_mult_arb.sv
// Self-checking bench for funct_generator_mult_arb (DATA_WIDTH=32, N_REQ=4,
// MULT_LAT=2). A behavioural model predicts each grant, pushes the expected
// tagged product into a queue on every accepted transfer and pops it when the
// result is consumed. Honours FUNCT_GEN_ARB_FIXPRIO_EN in its grant model.

module tb_funct_generator_mult_arb;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int ML = 2;

`ifdef FUNCT_GEN_ARB_FIXPRIO_EN
    localparam int PTR_RST = 1;
`else
    localparam int PTR_RST = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    reqValid;
    logic [NR*DW-1:0] reqA;
    logic [NR*DW-1:0] reqB;
    logic [NR-1:0]    reqReady;
    logic             resValid;
    logic             resReady;
    logic [IW-1:0]    resId;
    logic [2*DW-1:0]  resData;
    logic             busy;

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          edgeNo;
    } entry_t;

    entry_t sb[$];
    int     cycle      = 0;
    int     errorCount = 0;
    int     checkCount = 0;
    int     mPtr       = PTR_RST;
    logic   started    = 1'b0;

    funct_generator_mult_arb #(
        .DATA_WIDTH(DW),
        .N_REQ     (NR),
        .ID_WIDTH  (IW),
        .MULT_LAT  (ML)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(reqValid),
        .req_a_i    (reqA),
        .req_b_i    (reqB),
        .req_ready_o(reqReady),
        .res_valid_o(resValid),
        .res_ready_i(resReady),
        .res_id_o   (resId),
        .res_data_o (resData),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Model evaluated mid-cycle: inputs are stable and state reflects the
    // previous edge; it then records what the coming edge will do.
    always @(negedge clk) begin : monitor
        logic [NR-1:0] expGrant;
        logic          canAcc;
        logic          expValid;
        logic [DW-1:0] opA;
        logic [DW-1:0] opB;
        int            gid;
        int            c;
        entry_t        e;
        if (started) begin
            canAcc   = !(sb.size() == ML && !resReady);
            expGrant = '0;
            gid      = -1;
            if (canAcc && !rst) begin
`ifdef FUNCT_GEN_ARB_FIXPRIO_EN
                if (reqValid[0]) gid = 0;
                for (int i = 0; i < NR-1; i++) begin
                    c = 1 + (mPtr - 1 + i) % (NR - 1);
                    if (gid < 0 && reqValid[c]) gid = c;
                end
`else
                for (int i = 0; i < NR; i++) begin
                    c = (mPtr + i) % NR;
                    if (gid < 0 && reqValid[c]) gid = c;
                end
`endif
            end
            if (gid >= 0) expGrant[gid] = 1'b1;
            checkOutput("req_ready", 128'(reqReady), 128'(expGrant));

            expValid = (sb.size() > 0) && ((cycle - sb[0].edgeNo) >= ML-1);
            checkOutput("res_valid", 128'(resValid), 128'(expValid));
            if (expValid) begin
                checkOutput("res_id", 128'(resId), 128'(unsigned'(sb[0].id)));
                checkOutput("res_data", 128'(resData), 128'(sb[0].prod));
            end
            checkOutput("busy", 128'(busy), 128'(sb.size() != 0));

            if (rst) begin
                sb.delete();
                mPtr = PTR_RST;
            end else begin
                if (expValid && resReady) void'(sb.pop_front());
                if (gid >= 0) begin
                    opA      = reqA[gid*DW +: DW];
                    opB      = reqB[gid*DW +: DW];
                    e.id     = gid;
                    e.prod   = longint'(signed'(opA)) * longint'(signed'(opB));
                    e.edgeNo = cycle + 1;
                    sb.push_back(e);
`ifdef FUNCT_GEN_ARB_FIXPRIO_EN
                    if (gid != 0) mPtr = (gid == NR-1) ? 1 : gid + 1;
`else
                    mPtr = (gid + 1) % NR;
`endif
                end
            end
        end
    end

    task automatic setOperand(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        reqA[k*DW +: DW] = a;
        reqB[k*DW +: DW] = b;
    endtask

    // Drives one pattern for n cycles; returns one tick after a rising edge.
    task automatic applyStimulus(input logic [NR-1:0] v, input logic rdy, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            reqValid = v;
            resReady = rdy;
            if (rnd) begin
                for (int k = 0; k < NR; k++) setOperand(k, $urandom, $urandom);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        reqValid = '0;
        reqA     = '0;
        reqB     = '0;
        resReady = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        started = 1'b1;
        checkOutput("reset_valid", 128'(resValid), 128'(0));
        checkOutput("reset_id", 128'(resId), 128'(0));
        checkOutput("reset_data", 128'(resData), 128'(0));
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_ready", 128'(reqReady), 128'(0));
        applyStimulus('0, 1'b1, 1, 1'b0);
        rst = 1'b0;

        // Lone requester 2: -7 * 300000
        setOperand(2, -32'sd7, 32'sd300000);
        applyStimulus(4'b0100, 1'b1, 1, 1'b0);
        applyStimulus('0, 1'b1, 4, 1'b0);
        checkOutput("single_busy_after", 128'(busy), 128'(0));

        // Realign the pointer, then all requesters continuously
        rst = 1'b1;
        applyStimulus('0, 1'b1, 1, 1'b0);
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b1, 12, 1'b1);
        applyStimulus(4'b1110, 1'b1, 6, 1'b1);
        applyStimulus('0, 1'b1, 3, 1'b0);

        // Operand extremes
        setOperand(0, 32'h8000_0000, 32'h8000_0000);
        applyStimulus(4'b0001, 1'b1, 1, 1'b0);
        setOperand(1, 32'h7FFF_FFFF, 32'h8000_0000);
        applyStimulus(4'b0010, 1'b1, 1, 1'b0);
        applyStimulus('0, 1'b1, 3, 1'b0);

        // Backpressure under continuous requests, then release
        applyStimulus(4'b1111, 1'b0, 5, 1'b1);
        checkOutput("bp_inflight", 128'(sb.size()), 128'(ML));
        applyStimulus(4'b1111, 1'b1, 6, 1'b1);
        applyStimulus('0, 1'b1, 4, 1'b0);

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            applyStimulus(4'($urandom), ($urandom_range(0, 3) != 0), 1, 1'b1);
        end
        applyStimulus('0, 1'b1, 5, 1'b0);

        // Reset with the pipeline full
        applyStimulus(4'b1111, 1'b0, 3, 1'b1);
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b0, 1, 1'b1);
        rst = 1'b0;
        reqValid = '0;
        resReady = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_valid", 128'(resValid), 128'(0));
        checkOutput("rst_mid_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;
        applyStimulus(4'b1011, 1'b1, 8, 1'b1);
        applyStimulus('0, 1'b1, 6, 1'b0);
        checkOutput("drain_empty", 128'(sb.size()), 128'(0));
        checkOutput("drain_busy", 128'(busy), 128'(0));

        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
